hh_gate_scheduler: RTL and testbench

- Time-multiplexes one shared Hodgkin-Huxley gating-update unit across the m, h and n gates for each integration step.
- Owns the gate state registers, in unsigned Q1.15 with 1.0 = 0x8000.
- Latches membrane voltage once per step, issues m→h→n update requests over a valid/ready handshake, captures the results, then pulses step_done.
- Sits between the neuron step controller and the gate-update datapath.

---
 rtl/hh_pkg.sv | 23 ++
 rtl/hh_gate_scheduler.sv | 155 +++++++++++++++
 tb/tb_hh_gate_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hh_pkg.sv
// Shared types and constants for the Hodgkin-Huxley gate scheduler.
// Gate values are unsigned Q1.15, where 1.0 = 16'h8000.
package hh_pkg;

  typedef enum logic [1:0] {
    GATE_M = 2'd0,
    GATE_H = 2'd1,
    GATE_N = 2'd2
  } gate_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam logic [15:0] ONE            = 16'h8000;
  localparam logic [15:0] M_INIT_DEFAULT = 16'h06C9;
  localparam logic [15:0] H_INIT_DEFAULT = 16'h4C4A;
  localparam logic [15:0] N_INIT_DEFAULT = 16'h28B4;

endpackage

// File: rtl/hh_gate_scheduler.sv
// Shares one gate-update unit across the m, h and n gates for each integration step.
// Optional: define HH_GATE_CLAMP_EN to saturate captured gate values at 1.0 (16'h8000).
//
// state    | meaning
// ST_IDLE  | waiting for step_req; voltage latched on start
// ST_ISSUE | request for the selected gate presented until gu_ready
// ST_WAIT  | waiting for the response or the watchdog to expire
// ST_DONE  | one-cycle step_done pulse
module hh_gate_scheduler
  import hh_pkg::*;
#(
  parameter logic [15:0] M_INIT      = M_INIT_DEFAULT,
  parameter logic [15:0] H_INIT      = H_INIT_DEFAULT,
  parameter logic [15:0] N_INIT      = N_INIT_DEFAULT,
  parameter int          RSP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_req,
  input  logic [15:0] v_in,
  output logic        step_busy,
  output logic        step_done,
  output logic        err_timeout,
  output logic        gu_valid,
  input  logic        gu_ready,
  output logic [1:0]  gu_sel,
  output logic [15:0] gu_v,
  output logic [15:0] gu_x,
  input  logic        gu_rsp_valid,
  input  logic [15:0] gu_rsp_x,
  output logic [15:0] m_q,
  output logic [15:0] h_q,
  output logic [15:0] n_q
);

  localparam logic [7:0] TMO_LAST = 8'(RSP_TIMEOUT - 1);

  sched_state_e r_state;
  sched_state_e w_next;

  logic [1:0]  r_sel;
  logic [15:0] r_v;
  logic [15:0] r_m;
  logic [15:0] r_h;
  logic [15:0] r_n;
  logic [7:0]  r_cnt;
  logic        r_err;

  logic        w_capture;
  logic        w_expire;
  logic        w_advance;
  logic [15:0] w_store;

  assign w_capture = (r_state == ST_WAIT) && gu_rsp_valid;
  // A response arriving on the last watchdog cycle wins over the timeout.
  assign w_expire  = (r_state == ST_WAIT) && !gu_rsp_valid && (r_cnt == TMO_LAST);
  assign w_advance = w_capture || w_expire;

`ifdef HH_GATE_CLAMP_EN
  assign w_store = (gu_rsp_x > ONE) ? ONE : gu_rsp_x;
`else
  assign w_store = gu_rsp_x;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    gu_valid  = 1'b0;
    step_busy = 1'b1;
    step_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        step_busy = 1'b0;
        if (step_req) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        gu_valid = 1'b1;
        if (gu_ready) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_advance) w_next = (r_sel == GATE_N) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        step_done = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel <= GATE_M;
      r_v   <= 16'h0000;
      r_m   <= M_INIT;
      r_h   <= H_INIT;
      r_n   <= N_INIT;
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (step_req) begin
            r_v   <= v_in;
            r_sel <= GATE_M;
          end
        end
        ST_ISSUE: begin
          if (gu_ready) r_cnt <= 8'd0;
        end
        ST_WAIT: begin
          if (w_capture) begin
            case (r_sel)
              GATE_M:  r_m <= w_store;
              GATE_H:  r_h <= w_store;
              GATE_N:  r_n <= w_store;
              default: ;
            endcase
          end else if (w_expire) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
          if (w_advance && (r_sel != GATE_N)) r_sel <= r_sel + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gu_x = r_m;
    case (r_sel)
      GATE_M:  gu_x = r_m;
      GATE_H:  gu_x = r_h;
      GATE_N:  gu_x = r_n;
      default: gu_x = r_m;
    endcase
  end

  assign gu_sel      = r_sel;
  assign gu_v        = r_v;
  assign m_q         = r_m;
  assign h_q         = r_h;
  assign n_q         = r_n;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_hh_gate_scheduler.sv
// Scoreboard bench for hh_gate_scheduler: a responder emulates the gate unit,
// monitors compare requests and step results against a step-level reference model.
module tb_hh_gate_scheduler;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] v;
    logic [15:0] x;
  } req_t;

  typedef struct {
    int          rdy;
    int          rsp;
    bit          to;
    logic [15:0] val;
  } plan_t;

  typedef struct {
    logic [15:0] m;
    logic [15:0] h;
    logic [15:0] n;
    logic        err;
  } done_t;

  localparam logic [15:0] M0 = 16'h06C9;
  localparam logic [15:0] H0 = 16'h4C4A;
  localparam logic [15:0] N0 = 16'h28B4;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_req;
  logic [15:0] v_in;
  logic        step_busy, step_done, err_timeout, gu_valid, gu_ready, gu_rsp_valid;
  logic [1:0]  gu_sel;
  logic [15:0] gu_v, gu_x, gu_rsp_x, m_q, h_q, n_q;

  int total = 0;
  int bad   = 0;

  req_t  req_q[$];
  plan_t plan_q[$];
  done_t done_q[$];
  plan_t cur[3];
  logic [15:0] mdl[3];
  logic        mdl_err;

  hh_gate_scheduler dut (
    .clk(clk), .reset(reset), .step_req(step_req), .v_in(v_in),
    .step_busy(step_busy), .step_done(step_done), .err_timeout(err_timeout),
    .gu_valid(gu_valid), .gu_ready(gu_ready), .gu_sel(gu_sel), .gu_v(gu_v),
    .gu_x(gu_x), .gu_rsp_valid(gu_rsp_valid), .gu_rsp_x(gu_rsp_x),
    .m_q(m_q), .h_q(h_q), .n_q(n_q)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] stored(input logic [15:0] x);
`ifdef HH_GATE_CLAMP_EN
    return (x > 16'h8000) ? 16'h8000 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gate-unit emulation: consumes one plan per request.
  initial begin
    plan_t p;
    gu_ready     = 1'b0;
    gu_rsp_valid = 1'b0;
    gu_rsp_x     = 16'h0000;
    tick();
    forever begin
      if (gu_valid && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        repeat (p.rdy) tick();
        gu_ready = 1'b1;
        tick();
        gu_ready = 1'b0;
        if (!p.to) begin
          repeat (p.rsp) tick();
          gu_rsp_valid = 1'b1;
          gu_rsp_x     = p.val;
          tick();
          gu_rsp_valid = 1'b0;
          gu_rsp_x     = 16'($urandom);
        end
      end else begin
        tick();
      end
    end
  end

  // Request monitor: every presented request must match the head, which pops on accept.
  always @(negedge clk) begin
    if (!reset && gu_valid) begin
      if (req_q.size() == 0) begin
        chk("req_unexpected_valid", {15'd0, gu_valid}, 16'd0);
      end else begin
        chk("req_sel", {14'd0, gu_sel}, {14'd0, req_q[0].sel});
        chk("req_v", gu_v, req_q[0].v);
        chk("req_x", gu_x, req_q[0].x);
        if (gu_ready) void'(req_q.pop_front());
      end
    end
  end

  // Step-result monitor.
  always @(negedge clk) begin
    done_t d;
    if (!reset && step_done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", {15'd0, step_done}, 16'd0);
      end else begin
        d = done_q.pop_front();
        chk("done_m", m_q, d.m);
        chk("done_h", h_q, d.h);
        chk("done_n", n_q, d.n);
        chk("done_err", {15'd0, err_timeout}, {15'd0, d.err});
        chk("done_busy", {15'd0, step_busy}, 16'd1);
      end
    end
  end

  task automatic run_step(input logic [15:0] v, output int lat);
    for (int g = 0; g < 3; g++) begin
      req_q.push_back('{2'(g), v, mdl[g]});
      plan_q.push_back(cur[g]);
      if (cur[g].to) mdl_err = 1'b1;
      else mdl[g] = stored(cur[g].val);
    end
    done_q.push_back('{mdl[0], mdl[1], mdl[2], mdl_err});
    @(negedge clk);
    step_req = 1'b1;
    v_in     = v;
    lat      = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        step_req = 1'b0;
        v_in     = 16'($urandom);
      end
      if (lat == 3) step_req = 1'b1;  // ignored while busy
      if (lat == 4) step_req = 1'b0;
    end while (!step_done && lat < 3000);
    if (!step_done) begin
      total++;
      bad++;
      $display("FAIL step_done_wait actual=none required=pulse within 3000 cycles");
    end
    @(negedge clk);
    chk("idle_after_done", {15'd0, step_busy}, 16'd0);
  endtask

  task automatic rand_plans();
    for (int g = 0; g < 3; g++) begin
      cur[g].rdy = $urandom_range(0, 4);
      cur[g].rsp = $urandom_range(0, 6);
      cur[g].to  = ($urandom_range(0, 9) == 0);
      cur[g].val = ($urandom_range(0, 3) == 0) ? 16'(16'h8000 + $urandom_range(0, 16'h7FFF))
                                               : 16'($urandom_range(0, 16'h8000));
    end
  endtask

  task automatic check_init(input string tag);
    chk({tag, "_m"}, m_q, M0);
    chk({tag, "_h"}, h_q, H0);
    chk({tag, "_n"}, n_q, N0);
    chk({tag, "_busy"}, {15'd0, step_busy}, 16'd0);
    chk({tag, "_err"}, {15'd0, err_timeout}, 16'd0);
    chk({tag, "_valid"}, {15'd0, gu_valid}, 16'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int cnt;
    reset    = 1'b1;
    step_req = 1'b0;
    v_in     = 16'h0000;
    mdl[0] = M0; mdl[1] = H0; mdl[2] = N0;
    mdl_err = 1'b0;
    repeat (3) @(negedge clk);
    check_init("rst");
    chk("rst_sel", {14'd0, gu_sel}, 16'd0);
    chk("rst_v", gu_v, 16'd0);
    chk("rst_done", {15'd0, step_done}, 16'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_init("idle");

    // Nominal step: zero-wait handshakes, known responses, fixed latency.
    cur[0] = '{0, 0, 1'b0, 16'h0700};
    cur[1] = '{0, 0, 1'b0, 16'h4C00};
    cur[2] = '{0, 0, 1'b0, 16'h2900};
    run_step(16'hC100, lat);
    chk("latency", 16'(lat), 16'd7);
    chk("nominal_m", m_q, 16'h0700);
    chk("nominal_h", h_q, 16'h4C00);
    chk("nominal_n", n_q, 16'h2900);

    // h request stalled by gu_ready for 5 cycles.
    cur[0] = '{1, 2, 1'b0, 16'h0710};
    cur[1] = '{5, 1, 1'b0, 16'h4B00};
    cur[2] = '{0, 3, 1'b0, 16'h2A00};
    run_step(16'hBF00, lat);

    // n never answers: watchdog abandons it, error is sticky.
    cur[0] = '{0, 0, 1'b0, 16'h0720};
    cur[1] = '{0, 0, 1'b0, 16'h4A00};
    cur[2] = '{0, 0, 1'b1, 16'h0000};
    run_step(16'h0A00, lat);
    chk("tmo_n_kept", n_q, 16'h2A00);
    chk("tmo_err", {15'd0, err_timeout}, 16'd1);
    chk("tmo_latency_min", 16'(lat > 64), 16'd1);

    // Over-range response on m.
    cur[0] = '{0, 0, 1'b0, 16'h9000};
    cur[1] = '{0, 0, 1'b0, 16'h4900};
    cur[2] = '{0, 0, 1'b0, 16'h2B00};
    run_step(16'hC200, lat);
    chk("clamp_m", m_q, stored(16'h9000));
    chk("err_sticky", {15'd0, err_timeout}, 16'd1);

    for (int i = 0; i < 30; i++) begin
      rand_plans();
      run_step(16'($urandom), lat);
    end

    // Reset while waiting for the h response.
    cur[0] = '{0, 0, 1'b0, 16'h1111};
    cur[1] = '{0, 0, 1'b1, 16'h2222};
    req_q.push_back('{2'd0, 16'h9C40, mdl[0]});
    req_q.push_back('{2'd1, 16'h9C40, mdl[1]});
    plan_q.push_back(cur[0]);
    plan_q.push_back(cur[1]);
    @(negedge clk);
    step_req = 1'b1;
    v_in     = 16'h9C40;
    @(negedge clk);
    step_req = 1'b0;
    cnt = 0;
    while (!(gu_sel == 2'd1 && !gu_valid && step_busy) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) begin
      total++;
      bad++;
      $display("FAIL reach_wait_h actual=not reached required=WAIT for h");
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_init("midrst");
    chk("midrst_sel", {14'd0, gu_sel}, 16'd0);
    chk("midrst_v", gu_v, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    req_q.delete();
    plan_q.delete();
    done_q.delete();
    mdl[0] = M0; mdl[1] = H0; mdl[2] = N0;
    mdl_err = 1'b0;
    tick();
    gu_rsp_valid = 1'b1;
    gu_rsp_x     = 16'h1234;
    tick();
    gu_rsp_valid = 1'b0;
    @(negedge clk);
    check_init("late_rsp");

    for (int i = 0; i < 6; i++) begin
      rand_plans();
      run_step(16'($urandom), lat);
    end

    repeat (4) @(negedge clk);
    chk("req_q_drained", 16'(req_q.size()), 16'd0);
    chk("done_q_drained", 16'(done_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
